// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared types and helpers for the memory access stage
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MemAccessWidth;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } MemStageState;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        rd_w_enable;
    logic [4:0]  rd_addr;
  } WritebackStagePipeReg;

  // Encoding 3 is reserved and behaves as a full word.
  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] offset);
    case (MemAccessWidth'(width))
      MEM_BYTE: lane_mask = 4'b0001 << offset;
      MEM_HALF: lane_mask = 4'b0011 << offset;
      default:  lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_data_extender.sv
// rtl/load_data_extender.sv - selects the addressed byte/half of a read word and extends it
module load_data_extender
  import memory_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (MemAccessWidth'(width))
      MEM_BYTE: result = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: result = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - issues loads/stores over req/ack, stalls while pending, drives writeback
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       exPc,
  input  logic [31:0]       exAluResult,
  input  logic [DATA_W-1:0] exWData,
  input  logic [1:0]        exMemAccessWidth,
  input  logic              exRdWEnable,
  input  logic [4:0]        exRdAddr,
  input  logic              exRdForwardable,
  input  logic              exIsLoad,
  input  logic              exIsStore,
  input  logic              exIsLoadUnsigned,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [3:0]        dmemBe,
  output logic [DATA_W-1:0] dmemWData,
  input  logic              dmemAck,
  input  logic [DATA_W-1:0] dmemRData,
  output logic              memStall,
  output logic              misalignFault,
  output logic [31:0]       memBypassData,
  output logic [31:0]       wbPc,
  output logic [31:0]       wbData,
  output logic              wbRdWEnable,
  output logic [4:0]        wbRdAddr
);

  MemStageState         state_q, state_d;
  WritebackStagePipeReg wb_q, wb_d;

  logic        is_mem;
  logic        misaligned;
  logic        access;
  logic        load_done;
  logic [31:0] load_ext;
  logic [31:0] result_data;

  load_data_extender u_ext (
    .rdata       (dmemRData),
    .addr_lo     (exAluResult[1:0]),
    .width       (exMemAccessWidth),
    .is_unsigned (exIsLoadUnsigned),
    .result      (load_ext)
  );

  always_comb begin
    is_mem     = exIsLoad | exIsStore;
    misaligned = is_mem &&
                 (((exMemAccessWidth == MEM_HALF) && exAluResult[0]) ||
                  (exMemAccessWidth[1] && (exAluResult[1:0] != 2'b00)));
    access     = is_mem && !misaligned;
  end

  // Request fields come straight from the ex* inputs, which upstream holds during a stall.
  always_comb begin
    state_d       = state_q;
    dmemReq       = 1'b0;
    memStall      = 1'b0;
    misalignFault = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          misalignFault = misaligned;
          if (access) begin
            dmemReq = 1'b1;
            if (!dmemAck) begin
              state_d  = WAIT;
              memStall = 1'b1;
            end
          end
        end
        WAIT: begin
          dmemReq  = 1'b1;
          memStall = !dmemAck;
          if (dmemAck) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dmemWe   = dmemReq & exIsStore;
    dmemAddr = {exAluResult[ADDR_W-1:2], 2'b00};
    dmemBe   = lane_mask(exMemAccessWidth, exAluResult[1:0]);
    case (MemAccessWidth'(exMemAccessWidth))
      MEM_BYTE: dmemWData = {4{exWData[7:0]}};
      MEM_HALF: dmemWData = {2{exWData[15:0]}};
      default:  dmemWData = exWData;
    endcase
  end

  always_comb begin
    load_done     = dmemReq & dmemAck & exIsLoad;
    result_data   = load_done ? load_ext : exAluResult;
    memBypassData = exRdForwardable ? result_data : 32'd0;
  end

  always_comb begin
    wb_d = '0;
    if (!memStall) begin
      wb_d.pc          = exPc;
      wb_d.data        = result_data;
      wb_d.rd_w_enable = exRdWEnable & ~exIsStore & ~misaligned;
      wb_d.rd_addr     = exRdAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  assign wbPc        = wb_q.pc;
  assign wbData      = wb_q.data;
  assign wbRdWEnable = wb_q.rd_w_enable;
  assign wbRdAddr    = wb_q.rd_addr;

endmodule
